// File: rtl/game_timer_pkg.sv
// ---------------------------------------------------------------------------
// game_timer_pkg
//   Shared constants and helpers for the BCD game clock.
//   DIGIT_W       width of one BCD digit
//   DIGIT_MAX     largest value of a decimal digit (seconds units, minutes)
//   SEC_TENS_MAX  largest value of the seconds-tens digit
//   bcd_clamp     saturate a raw nibble to a digit's legal maximum
//   bcd_lt        magnitude compare of two BCD times (zero-extended to
//                 BCD_MAX_W; packed BCD orders the same as plain binary)
// ---------------------------------------------------------------------------
package game_timer_pkg;

    localparam int         DIGIT_W      = 4;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    // Widest time value: four minute digits plus two second digits.
    localparam int         BCD_MAX_W    = 24;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] digit,
                                             input logic [3:0] max_digit);
        return (digit > max_digit) ? max_digit : digit;
    endfunction

    function automatic logic bcd_lt(input logic [BCD_MAX_W-1:0] a,
                                    input logic [BCD_MAX_W-1:0] b);
        return a < b;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// ---------------------------------------------------------------------------
// bcd_digit_counter
//   One up/down BCD digit of the game clock, counting 0..MAX.
//   clk, resetn  system clock, synchronous active-low reset
//   clear        synchronous clear to zero
//   load         load load_digit (already clamped by the parent)
//   load_digit   preload value
//   step         a second tick is being applied to the whole time value
//   down         1: count down, 0: count up
//   cin          carry (up) / borrow (down) from the lower digit
//   q            current digit value
//   cout         carry out at MAX (up) or borrow out at 0 (down)
// ---------------------------------------------------------------------------
module bcd_digit_counter
    import game_timer_pkg::*;
#(
    parameter logic [3:0] MAX = DIGIT_MAX
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               clear,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_digit,
    input  logic               step,
    input  logic               down,
    input  logic               cin,
    output logic [DIGIT_W-1:0] q,
    output logic               cout
);

    // Combinational ripple so the whole carry/borrow chain settles within
    // one cycle; q itself is registered, so there is no loop.
    assign cout = cin && (down ? (q == '0) : (q == MAX));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= load_digit;
        end else if (step && cin) begin
            if (down) begin
                q <= (q == '0) ? MAX : q - 4'd1;
            end else begin
                q <= (q == MAX) ? '0 : q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/game_timer_bcd.sv
// ---------------------------------------------------------------------------
// game_timer_bcd
//   Parametrised BCD game clock (M..M:SS) with a 1 Hz prescaler, up/down
//   counting, pause, preload, saturate/wrap, expiry and overflow flags.
//
//   Parameters
//     TICK_DIV    clk cycles per one-second tick (>= 2)
//     MIN_DIGITS  number of BCD minute digits (1..4), W = 4*(MIN_DIGITS+2)
//     SAT         1: hold at max on up-overflow, 0: wrap to zero
//
//   Ports
//     clk, resetn  system clock, synchronous active-low reset
//     run          1: count, 0: pause (time and prescaler held)
//     mode_down    0: count up, 1: count down
//     clear        synchronous clear of time, prescaler and flags
//     load         one-cycle strobe, time_value <= clamped load_value
//     load_value   BCD preload {minute digits, sec tens, sec units}
//     time_value   current BCD time
//     sec_tick     one-cycle pulse in the cycle time_value steps
//     expired      sticky, a down-count reached zero
//     overflow     sticky, an up-count passed the maximum
//
//   Optional feature, macro BEST_TIME_EN:
//     capture      strobe to record time_value if it beats best_time
//     best_time    best (smallest) captured time, kept until resetn
//     best_valid   best_time holds a captured value
// ---------------------------------------------------------------------------
module game_timer_bcd
    import game_timer_pkg::*;
#(
    parameter int TICK_DIV   = 50_000_000,
    parameter int MIN_DIGITS = 2,
    parameter int SAT        = 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        run,
    input  logic                        mode_down,
    input  logic                        clear,
    input  logic                        load,
    input  logic [4*(MIN_DIGITS+2)-1:0] load_value,
`ifdef BEST_TIME_EN
    input  logic                        capture,
    output logic [4*(MIN_DIGITS+2)-1:0] best_time,
    output logic                        best_valid,
`endif
    output logic [4*(MIN_DIGITS+2)-1:0] time_value,
    output logic                        sec_tick,
    output logic                        expired,
    output logic                        overflow
);

    localparam int NDIG = MIN_DIGITS + 2;
    localparam int W    = DIGIT_W * NDIG;
    localparam int PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] prescaler;
    logic          tick_now;
    logic          at_limit;
    logic          step;
    logic          is_one;

    // clear and load both override a terminal prescaler, so the tick is lost.
    assign tick_now = run && (prescaler == TICK_LAST) && !clear && !load;

    // at_limit is the carry out of the top digit: all-max when counting up,
    // all-zero when counting down. The value freezes at zero going down and
    // at max going up when saturating; wrapping lets the chain roll to zero.
    assign at_limit = g_digit[NDIG-1].cout_w;
    assign step     = tick_now && !(at_limit && (mode_down || (SAT != 0)));
    assign is_one   = (time_value == W'(1));

    for (genvar i = 0; i < NDIG; i++) begin : g_digit
        // Digit 1 is the seconds-tens digit; everything else is decimal.
        localparam logic [3:0] DMAX = (i == 1) ? SEC_TENS_MAX : DIGIT_MAX;

        logic               cin_w;
        logic               cout_w;
        logic [DIGIT_W-1:0] q_w;

        if (i == 0) begin : g_lsd
            assign cin_w = 1'b1;
        end else begin : g_chain
            assign cin_w = g_digit[i-1].cout_w;
        end

        bcd_digit_counter #(
            .MAX(DMAX)
        ) u_digit (
            .clk        (clk),
            .resetn     (resetn),
            .clear      (clear),
            .load       (load),
            .load_digit (bcd_clamp(load_value[DIGIT_W*i +: DIGIT_W], DMAX)),
            .step       (step),
            .down       (mode_down),
            .cin        (cin_w),
            .q          (q_w),
            .cout       (cout_w)
        );

        assign time_value[DIGIT_W*i +: DIGIT_W] = q_w;
    end

    // Prescaler only advances while running, so a pause keeps the partial
    // second. Flags are sticky until clear, load or reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prescaler <= '0;
            sec_tick  <= 1'b0;
            expired   <= 1'b0;
            overflow  <= 1'b0;
        end else if (clear || load) begin
            prescaler <= '0;
            sec_tick  <= 1'b0;
            expired   <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            sec_tick <= tick_now;
            if (run) begin
                prescaler <= (prescaler == TICK_LAST) ? '0 : prescaler + 1'b1;
            end
            // A down step from exactly one second is the step that lands on zero.
            if (tick_now && mode_down && is_one) begin
                expired <= 1'b1;
            end
            if (tick_now && !mode_down && at_limit) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef BEST_TIME_EN
    // Capture compares the pre-edge time, so a capture coinciding with a
    // tick records the value before the step. clear/load do not touch it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            best_time  <= '0;
            best_valid <= 1'b0;
        end else if (capture &&
                     (!best_valid ||
                      bcd_lt(BCD_MAX_W'(time_value), BCD_MAX_W'(best_time)))) begin
            best_time  <= time_value;
            best_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_game_timer_bcd.sv
// ---------------------------------------------------------------------------
// tb_game_timer_bcd
//   Two instances share all inputs: one saturating (SAT=1), one wrapping
//   (SAT=0). A reference model keeps time as a plain count of seconds and
//   the prescaler as a cycle count; expected BCD is derived by division.
// ---------------------------------------------------------------------------
module tb_game_timer_bcd;

    localparam int TICK_DIV   = 4;
    localparam int MIN_DIGITS = 2;
    localparam int W          = 4 * (MIN_DIGITS + 2);
    localparam int MAX_SECS   = (10 ** MIN_DIGITS - 1) * 60 + 59;

    logic         clk = 1'b0;
    logic         resetn;
    logic         run;
    logic         mode_down;
    logic         clear;
    logic         load;
    logic [W-1:0] load_value;
    logic         capture;

    logic [W-1:0] tv_sat,  tv_wrap;
    logic         st_sat,  st_wrap;
    logic         ex_sat,  ex_wrap;
    logic         ov_sat,  ov_wrap;
`ifdef BEST_TIME_EN
    logic [W-1:0] bt_sat,  bt_wrap;
    logic         bv_sat,  bv_wrap;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: index 0 saturating, index 1 wrapping.
    int m_time  [2];
    bit m_exp   [2];
    bit m_ovf   [2];
    int m_best  [2];
    bit m_bval  [2];
    int m_phase;
    bit m_tick;

    always #5 clk = ~clk;

    game_timer_bcd #(
        .TICK_DIV(TICK_DIV), .MIN_DIGITS(MIN_DIGITS), .SAT(1)
    ) dut_sat (
        .clk(clk), .resetn(resetn), .run(run), .mode_down(mode_down),
        .clear(clear), .load(load), .load_value(load_value),
`ifdef BEST_TIME_EN
        .capture(capture), .best_time(bt_sat), .best_valid(bv_sat),
`endif
        .time_value(tv_sat), .sec_tick(st_sat), .expired(ex_sat), .overflow(ov_sat)
    );

    game_timer_bcd #(
        .TICK_DIV(TICK_DIV), .MIN_DIGITS(MIN_DIGITS), .SAT(0)
    ) dut_wrap (
        .clk(clk), .resetn(resetn), .run(run), .mode_down(mode_down),
        .clear(clear), .load(load), .load_value(load_value),
`ifdef BEST_TIME_EN
        .capture(capture), .best_time(bt_wrap), .best_valid(bv_wrap),
`endif
        .time_value(tv_wrap), .sec_tick(st_wrap), .expired(ex_wrap), .overflow(ov_wrap)
    );

    function automatic logic [W-1:0] to_bcd(input int secs);
        logic [W-1:0] r;
        int m, s;
        m = secs / 60;
        s = secs % 60;
        r = '0;
        r[3:0] = 4'(s % 10);
        r[7:4] = 4'(s / 10);
        for (int d = 0; d < MIN_DIGITS; d++) begin
            r[8 + 4*d +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    function automatic int clamp_secs(input logic [W-1:0] v);
        int u, t, m, dg;
        u = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        t = (v[7:4] > 4'd5) ? 5 : int'(v[7:4]);
        m = 0;
        for (int d = MIN_DIGITS - 1; d >= 0; d--) begin
            dg = int'(v[8 + 4*d +: 4]);
            if (dg > 9) dg = 9;
            m = m * 10 + dg;
        end
        return m * 60 + t * 10 + u;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    function automatic void model_step();
        for (int k = 0; k < 2; k++) begin
            if (resetn && capture && (!m_bval[k] || m_time[k] < m_best[k])) begin
                m_best[k] = m_time[k];
                m_bval[k] = 1'b1;
            end
        end
        if (!resetn) begin
            m_phase = 0;
            m_tick  = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_time[k] = 0; m_exp[k] = 1'b0; m_ovf[k] = 1'b0;
                m_best[k] = 0; m_bval[k] = 1'b0;
            end
        end else if (clear || load) begin
            m_phase = 0;
            m_tick  = 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_time[k] = clear ? 0 : clamp_secs(load_value);
                m_exp[k]  = 1'b0;
                m_ovf[k]  = 1'b0;
            end
        end else begin
            m_tick = run && (m_phase == TICK_DIV - 1);
            if (run) m_phase = (m_phase + 1) % TICK_DIV;
            if (m_tick) begin
                for (int k = 0; k < 2; k++) begin
                    if (mode_down) begin
                        if (m_time[k] > 0) begin
                            m_time[k]--;
                            if (m_time[k] == 0) m_exp[k] = 1'b1;
                        end
                    end else if (m_time[k] == MAX_SECS) begin
                        m_ovf[k] = 1'b1;
                        if (k == 1) m_time[k] = 0;
                    end else begin
                        m_time[k]++;
                    end
                end
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_tests++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic compare_all();
        checkOutput("time_sat",  32'(tv_sat),  32'(to_bcd(m_time[0])));
        checkOutput("time_wrap", 32'(tv_wrap), 32'(to_bcd(m_time[1])));
        checkOutput("tick_sat",  32'(st_sat),  32'(m_tick));
        checkOutput("tick_wrap", 32'(st_wrap), 32'(m_tick));
        checkOutput("exp_sat",   32'(ex_sat),  32'(m_exp[0]));
        checkOutput("exp_wrap",  32'(ex_wrap), 32'(m_exp[1]));
        checkOutput("ovf_sat",   32'(ov_sat),  32'(m_ovf[0]));
        checkOutput("ovf_wrap",  32'(ov_wrap), 32'(m_ovf[1]));
`ifdef BEST_TIME_EN
        checkOutput("best_sat",   32'(bt_sat),  32'(to_bcd(m_best[0])));
        checkOutput("best_wrap",  32'(bt_wrap), 32'(to_bcd(m_best[1])));
        checkOutput("bvalid_sat", 32'(bv_sat),  32'(m_bval[0]));
        checkOutput("bvalid_wrap",32'(bv_wrap), 32'(m_bval[1]));
`endif
    endtask

    // Drive one cycle of inputs, let the edge happen, then check 1 time unit later.
    task automatic applyStimulus(input logic r, input logic dn, input logic clr,
                                 input logic ld, input logic [W-1:0] lv,
                                 input logic cap);
        run        = r;
        mode_down  = dn;
        clear      = clr;
        load       = ld;
        load_value = lv;
        capture    = cap;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        logic [W-1:0] lv_r;
        logic         dn_r;

        resetn = 1'b0;
        run = 1'b0; mode_down = 1'b0; clear = 1'b0; load = 1'b0;
        load_value = '0; capture = 1'b0;
        m_phase = 0; m_tick = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_time[k] = 0; m_exp[k] = 1'b0; m_ovf[k] = 1'b0;
            m_best[k] = 0; m_bval[k] = 1'b0;
        end

        // Reset, count a little, then reset mid-count.
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        resetn = 1'b1;
        repeat (9) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        resetn = 1'b0;
        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("rst_time", 32'(tv_sat), 32'h0);
        checkOutput("rst_tick", 32'(st_sat), 32'h0);
        checkOutput("rst_exp",  32'(ex_sat), 32'h0);
        checkOutput("rst_ovf",  32'(ov_sat), 32'h0);
        resetn = 1'b1;

        // 00:59 rolls to 01:00 after TICK_DIV cycles with a single pulse.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h0059, 1'b0);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("carry_pre_tick", 32'(st_sat), 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("carry_time", 32'(tv_sat), 32'h0100);
        checkOutput("carry_tick", 32'(st_sat), 32'h1);

        // Pause keeps the partial second.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("single_pulse", 32'(st_sat), 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("pause_hold", 32'(tv_sat), 32'h0100);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("resume_early", 32'(st_sat), 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("resume_tick", 32'(st_sat), 32'h1);
        checkOutput("resume_time", 32'(tv_sat), 32'h0101);

        // Countdown to zero, then hold.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b0);
        repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("down_one", 32'(tv_sat), 32'h0001);
        repeat (4) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("down_zero", 32'(tv_sat), 32'h0000);
        checkOutput("down_exp",  32'(ex_sat), 32'h1);
        repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("zero_hold", 32'(tv_sat), 32'h0000);
        checkOutput("zero_exp",  32'(ex_sat), 32'h1);

        // Up-overflow at 99:59: saturate vs wrap.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h9959, 1'b0);
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        checkOutput("sat_time",  32'(tv_sat),  32'h9959);
        checkOutput("sat_ovf",   32'(ov_sat),  32'h1);
        checkOutput("wrap_time", 32'(tv_wrap), 32'h0000);
        checkOutput("wrap_ovf",  32'(ov_wrap), 32'h1);

        // Load clamping, clear beats load.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0A7F, 1'b0);
        checkOutput("clamp", 32'(tv_sat), 32'h0959);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0);
        checkOutput("clear_wins", 32'(tv_sat), 32'h0000);

`ifdef BEST_TIME_EN
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0130, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0125, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h0200, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        checkOutput("best_time",  32'(bt_sat), 32'h0125);
        checkOutput("best_valid", 32'(bv_sat), 32'h1);
`endif

        // Randomised traffic against the model.
        dn_r = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            resetn = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 49) == 0) dn_r = ~dn_r;
            case ($urandom_range(0, 3))
                0:       lv_r = W'($urandom);
                1:       lv_r = {8'h99, 4'h5, 4'($urandom_range(0, 9))};
                2:       lv_r = W'($urandom_range(0, 3));
                default: lv_r = {4'h0, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)),
                                 4'($urandom_range(0, 9))};
            endcase
            applyStimulus($urandom_range(0, 7) != 0, dn_r,
                          $urandom_range(0, 99) == 0,
                          $urandom_range(0, 29) == 0,
                          lv_r,
                          $urandom_range(0, 9) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
